ctr_mode_ctrl: RTL and testbench

- Sequencer that turns the AES-256 block core into a CTR-mode stream engine.
- Holds the 128-bit counter block and accepts one plaintext block per valid/ready handshake.
- Issues the counter block to the core with a start/done handshake, XORs the returned keystream with the held data block, and presents the result downstream.
- Sits between the data source/sink and `encryptiontop`. The key is wired directly to the core and is not handled here.

---
 rtl/ctr_mode_ctrl_if.sv | 32 +++
 rtl/ctr_mode_ctrl.sv | 112 +++++++++++
 tb/tb_ctr_mode_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_mode_ctrl_if.sv
// Handshake and data bus between the CTR-mode controller, the data
// source/sink and the AES block core. The controller uses the master
// modport; the surrounding environment uses the slave modport.
interface ctr_mode_ctrl_if;
  logic         iv_load;
  logic [127:0] iv_i;
  logic         din_valid;
  logic         din_ready;
  logic [127:0] din;
  logic         dout_valid;
  logic         dout_ready;
  logic [127:0] dout;
  logic         core_start;
  logic [127:0] core_block_o;
  logic         core_done;
  logic [127:0] core_result_i;
  logic         busy;
  logic         err;
  logic [31:0]  blk_count;

  modport master (
    input  iv_load, iv_i, din_valid, din, dout_ready, core_done, core_result_i,
    output din_ready, dout_valid, dout, core_start, core_block_o, busy, err,
           blk_count
  );

  modport slave (
    output iv_load, iv_i, din_valid, din, dout_ready, core_done, core_result_i,
    input  din_ready, dout_valid, dout, core_start, core_block_o, busy, err,
           blk_count
  );
endinterface

// File: rtl/ctr_mode_ctrl.sv
// CTR-mode sequencer around an AES block core. Holds the counter block,
// accepts one data block at a time, issues the counter to the core and
// XORs the returned keystream into the held block. A watchdog aborts a
// block when the core never answers.
module ctr_mode_ctrl #(
  parameter int CTR_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic           clk,
  input  logic           rst,
  ctr_mode_ctrl_if.master bus
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    ENCRYPT = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t              state;
  logic [127:0]        ctr_p0;
  logic [127:0]        din_p0;
  logic [127:0]        dout_p1;
  logic                vld_p1;
  logic                core_start_q;
  logic                err_q;
  logic [31:0]         blk_count_q;
  logic [WDOG_W-1:0]   wdog;

  // Only the low CTR_WIDTH bits count; the nonce field never sees a carry.
  function automatic logic [127:0] ctr_inc(input logic [127:0] blk);
    logic [127:0] nxt;
    nxt = blk;
    nxt[CTR_WIDTH-1:0] = blk[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
    return nxt;
  endfunction

  // Controller FSM: IV load, block capture, core handshake, result hold, watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ctr_p0       <= '0;
      din_p0       <= '0;
      dout_p1      <= '0;
      vld_p1       <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      blk_count_q  <= '0;
      wdog         <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iv_load) begin
            ctr_p0      <= bus.iv_i;
            blk_count_q <= '0;
            err_q       <= 1'b0;
            state       <= READY;
          end
        end
        READY: begin
          // A reload wins over a block offered in the same cycle.
          if (bus.iv_load) begin
            ctr_p0      <= bus.iv_i;
            blk_count_q <= '0;
            err_q       <= 1'b0;
          end else if (bus.din_valid) begin
            din_p0       <= bus.din;
            core_start_q <= 1'b1;
            wdog         <= '0;
            state        <= ENCRYPT;
          end
        end
        ENCRYPT: begin
          if (bus.core_done) begin
            dout_p1     <= din_p0 ^ bus.core_result_i;
            vld_p1      <= 1'b1;
            ctr_p0      <= ctr_inc(ctr_p0);
            blk_count_q <= blk_count_q + 32'd1;
            state       <= OUTPUT;
          end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
            // Core never answered: drop the block, keep the counter.
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        OUTPUT: begin
          if (bus.dout_ready) begin
            vld_p1 <= 1'b0;
            state  <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready    = (state == READY) && !bus.iv_load;
  assign bus.dout_valid   = vld_p1;
  assign bus.dout         = dout_p1;
  assign bus.core_start   = core_start_q;
  assign bus.core_block_o = ctr_p0;
  assign bus.busy         = (state == ENCRYPT) || (state == OUTPUT);
  assign bus.err          = err_q;
  assign bus.blk_count    = blk_count_q;

endmodule

// File: tb/tb_ctr_mode_ctrl.sv
// Randomized bench for ctr_mode_ctrl with a behavioural AES-core stand-in
// and a transaction-level CTR reference model.
module tb_ctr_mode_ctrl;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ctr_mode_ctrl_if bus ();

  ctr_mode_ctrl #(.CTR_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counter block as nonce plus a 32-bit wrapping count.
  logic [95:0]  exp_nonce;
  logic [31:0]  exp_low;
  logic [31:0]  exp_blk;

  // Core stand-in state.
  int           ks_mode = 0;     // 0 identity, 1 mixing, 2 known-answer table
  int           core_lat = 0;
  bit           core_hang = 1'b0;
  bit           pend = 1'b0;
  int           cnt = 0;
  logic [127:0] pend_blk;
  int           start_cnt = 0;
  int           done_cnt = 0;

  localparam logic [127:0] KAT_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] KAT_P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] KAT_C1 = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] KAT_P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] KAT_C2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] KAT_B2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;

  function automatic logic [127:0] ks(input logic [127:0] b);
    logic [127:0] r;
    r = {b[63:0], b[127:64]} ^ {b[126:0], b[127]} ^ 128'h0123456789abcdef_fedcba9876543210;
    if (ks_mode == 0) r = b;
    else if (ks_mode == 2) begin
      if (b == KAT_IV) r = KAT_P1 ^ KAT_C1;
      else if (b == KAT_B2) r = KAT_P2 ^ KAT_C2;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_ctr();
    return {exp_nonce, exp_low};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle; also runs the core stand-in at the falling edge.
  task automatic tick();
    @(negedge clk);
    bus.core_done     = 1'b0;
    bus.core_result_i = {$urandom, $urandom, $urandom, $urandom};
    if (bus.core_start) begin
      start_cnt++;
      pend     = 1'b1;
      cnt      = core_lat;
      pend_blk = bus.core_block_o;
    end
    if (pend && !core_hang) begin
      if (cnt == 0) begin
        bus.core_done     = 1'b1;
        bus.core_result_i = ks(pend_blk);
        pend              = 1'b0;
        done_cnt++;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic load_iv(input logic [127:0] v);
    bus.iv_i    = v;
    bus.iv_load = 1'b1;
    #1;
    check_eq("ivload_din_ready_low", bus.din_ready, 1'b0);
    tick();
    bus.iv_load = 1'b0;
    #1;
    exp_nonce = v[127:32];
    exp_low   = v[31:0];
    exp_blk   = '0;
    check_eq("ivload_din_ready", bus.din_ready, 1'b1);
    check_eq("ivload_ctr", bus.core_block_o, exp_ctr());
    check_eq("ivload_blk_count", bus.blk_count, exp_blk);
    check_eq("ivload_err", bus.err, 1'b0);
  endtask

  task automatic do_block(input logic [127:0] d, input int stall, input int lat);
    logic [127:0] exp_out;
    int s0;
    int n;
    core_lat = lat;
    s0 = start_cnt;
    check_eq("blk_din_ready", bus.din_ready, 1'b1);
    bus.din       = d;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    bus.din       = {$urandom, $urandom, $urandom, $urandom};
    check_eq("blk_core_start", bus.core_start, 1'b1);
    check_eq("blk_busy", bus.busy, 1'b1);
    exp_out = d ^ ks(exp_ctr());
    n = 0;
    while (bus.dout_valid !== 1'b1 && n < 64) begin
      check_eq("blk_core_block", bus.core_block_o, exp_ctr());
      tick();
      n++;
    end
    check_eq("blk_dout_valid", bus.dout_valid, 1'b1);
    check_eq("blk_dout", bus.dout, exp_out);
    exp_low = exp_low + 32'd1;
    exp_blk = exp_blk + 32'd1;
    check_eq("blk_count", bus.blk_count, exp_blk);
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("stall_dout", bus.dout, exp_out);
      check_eq("stall_dout_valid", bus.dout_valid, 1'b1);
      check_eq("stall_din_ready", bus.din_ready, 1'b0);
    end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check_eq("post_dout_valid", bus.dout_valid, 1'b0);
    check_eq("post_din_ready", bus.din_ready, 1'b1);
    check_eq("post_busy", bus.busy, 1'b0);
    check_eq("post_ctr", bus.core_block_o, exp_ctr());
    check_eq("start_pulses", 128'(start_cnt - s0), 128'd1);
  endtask

  initial begin
    bit saw_vld;
    int s0;
    int d0;
    bus.iv_load       = 1'b0;
    bus.iv_i          = '0;
    bus.din_valid     = 1'b0;
    bus.din           = '0;
    bus.dout_ready    = 1'b0;
    bus.core_done     = 1'b0;
    bus.core_result_i = '0;
    exp_nonce = '0;
    exp_low   = '0;
    exp_blk   = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_din_ready", bus.din_ready, 1'b0);
    check_eq("rst_dout_valid", bus.dout_valid, 1'b0);
    check_eq("rst_core_start", bus.core_start, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_dout", bus.dout, '0);
    check_eq("rst_core_block", bus.core_block_o, '0);
    check_eq("rst_blk_count", bus.blk_count, '0);
    rst = 1'b0;
    tick();
    check_eq("idle_din_ready", bus.din_ready, 1'b0);

    // Known-answer blocks
    ks_mode = 2;
    load_iv(KAT_IV);
    do_block(KAT_P1, 0, 3);
    check_eq("kat_c1", bus.dout, KAT_C1);
    check_eq("kat_block2", bus.core_block_o, KAT_B2);
    do_block(KAT_P2, 1, 0);
    check_eq("kat_c2", bus.dout, KAT_C2);

    // Counter wrap with identity keystream
    ks_mode = 0;
    load_iv(128'h00000000_00000000_00000000_ffffffff);
    do_block('0, 0, 2);
    check_eq("wrap_dout1", bus.dout, 128'h00000000_00000000_00000000_ffffffff);
    check_eq("wrap_ctr", bus.core_block_o, '0);
    do_block('0, 0, 1);
    check_eq("wrap_dout2", bus.dout, '0);
    check_eq("wrap_blk_count", bus.blk_count, 32'd2);

    // Reload has priority over a simultaneous block
    ks_mode = 1;
    s0 = start_cnt;
    bus.iv_i      = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    bus.iv_load   = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = {4{32'h5a5a5a5a}};
    tick();
    bus.iv_load   = 1'b0;
    bus.din_valid = 1'b0;
    tick();
    exp_nonce = 96'hdeadbeef_cafef00d_12345678;
    exp_low   = 32'h9abcdef0;
    exp_blk   = '0;
    check_eq("prio_no_start", 128'(start_cnt - s0), 128'd0);
    check_eq("prio_busy", bus.busy, 1'b0);
    check_eq("prio_ctr", bus.core_block_o, exp_ctr());
    check_eq("prio_blk_count", bus.blk_count, '0);
    check_eq("prio_din_ready", bus.din_ready, 1'b1);

    // Long sink backpressure
    s0 = start_cnt;
    do_block({$urandom, $urandom, $urandom, $urandom}, 20, 4);

    // Randomized traffic with occasional reloads
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 4) == 0)
        load_iv({$urandom, $urandom, $urandom, $urandom_range(32'hfffffffc, 32'hffffffff)});
      do_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
               $urandom_range(0, 6));
    end

    // Watchdog: core never answers
    core_hang = 1'b1;
    saw_vld = 1'b0;
    bus.din       = {4{$urandom}};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    check_eq("wd_start", bus.core_start, 1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      saw_vld |= bus.dout_valid;
    end
    check_eq("wd_err_early", bus.err, 1'b0);
    check_eq("wd_busy_early", bus.busy, 1'b1);
    tick();
    saw_vld |= bus.dout_valid;
    check_eq("wd_err", bus.err, 1'b1);
    check_eq("wd_idle_busy", bus.busy, 1'b0);
    check_eq("wd_idle_din_ready", bus.din_ready, 1'b0);
    check_eq("wd_no_dout", saw_vld, 1'b0);
    check_eq("wd_ctr_kept", bus.core_block_o, exp_ctr());
    core_hang = 1'b0;
    pend      = 1'b0;
    load_iv(128'h11112222_33334444_55556666_fffffffe);
    do_block({$urandom, $urandom, $urandom, $urandom}, 0, 2);

    // Asynchronous reset during ENCRYPT, late done afterwards
    d0 = done_cnt;
    core_lat      = 6;
    bus.din       = {4{$urandom}};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    check_eq("rm_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rm_busy0", bus.busy, 1'b0);
    check_eq("rm_core_start0", bus.core_start, 1'b0);
    check_eq("rm_core_block0", bus.core_block_o, '0);
    check_eq("rm_blk_count0", bus.blk_count, '0);
    check_eq("rm_dout0", bus.dout, '0);
    check_eq("rm_err0", bus.err, 1'b0);
    tick();
    rst = 1'b0;
    saw_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_vld |= bus.dout_valid | bus.busy;
    end
    check_eq("rm_late_done_seen", 128'(done_cnt - d0), 128'd1);
    check_eq("rm_ignored", saw_vld, 1'b0);
    check_eq("rm_din_ready", bus.din_ready, 1'b0);
    load_iv(128'h0badf00d_0badf00d_0badf00d_00000010);
    do_block({$urandom, $urandom, $urandom, $urandom}, 2, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
